// File: rtl/csr_pkg.sv
// csr_pkg
// Shared constants for the machine-mode CSR file: CSR addresses, mstatus and
// mip/mie bit positions, the misa value and the reset values of the
// registers that do not reset to zero.
// No ports; imported by csr_machine_file and csr_counter64.
package csr_pkg;

    // Read-only identification CSRs
    localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID       = 12'hF14;

    // Machine trap setup / handling
    localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
    localparam logic [11:0] ADDR_MISA          = 12'h301;
    localparam logic [11:0] ADDR_MIE           = 12'h304;
    localparam logic [11:0] ADDR_MTVEC         = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] ADDR_MEPC          = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
    localparam logic [11:0] ADDR_MTVAL         = 12'h343;
    localparam logic [11:0] ADDR_MIP           = 12'h344;

    // Machine counters and their user-level read-only aliases
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // mip/mie bit positions; local interrupt i lives at MIP_LOCAL_BASE + i
    localparam int MIP_MSI        = 3;
    localparam int MIP_MTI        = 7;
    localparam int MIP_MEI        = 11;
    localparam int MIP_LOCAL_BASE = 16;

    // mcountinhibit bit positions
    localparam int INHIBIT_CY = 0;
    localparam int INHIBIT_IR = 2;

    // Fixed values and non-zero reset values
    localparam logic [31:0] MISA_VALUE  = 32'h4000_0010;
    localparam logic [31:0] MTVEC_RESET = 32'h0000_0004;

    // Mask of the interrupt bits present in mip/mie for a given local count
    function automatic logic [31:0] irqMask(input int numLocal);
        logic [63:0] localBits;
        localBits = ((64'h1 << numLocal) - 64'h1) << MIP_LOCAL_BASE;
        return localBits[31:0] | (32'h1 << MIP_MSI) | (32'h1 << MIP_MTI) | (32'h1 << MIP_MEI);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64
// A 64-bit free-running counter with a software-writable low and high half.
// Ports:
//   clk, reset       - clock and asynchronous active-high reset
//   inc              - count enable for this edge
//   inhibit          - freezes the counter (mcountinhibit bit)
//   wr_lo, wr_hi     - load din into the low / high half this edge
//   din              - write data
//   count            - current 64-bit value
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] din,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // A software write to either half wins over counting on that edge, so the
    // value read back right after the write is exactly what was written.
    always_comb begin
        count_d = count_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) count_d[31:0]  = din;
            if (wr_hi) count_d[63:32] = din;
        end else if (inc && !inhibit) begin
            count_d = count_q + 64'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/csr_machine_file.sv
// csr_machine_file
// Machine-mode CSR file: identification, trap setup/handling, interrupt
// pending/enable with fixed-priority selection, and the cycle/instret counters.
// Ports:
//   clk, reset                       - clock, asynchronous active-high reset
//   din, addr, write_en, read_en     - CSR access
//   dout, illegal                    - read data, illegal-access flag
//   trap_en, trap_pc, trap_int,
//   trap_cause, trap_val             - trap entry
//   mret_en, instret_inc             - trap return, retired-instruction pulse
//   irq_mtip, irq_meip, irq_local    - interrupt sources
//   irq_req, irq_cause               - pending enabled interrupt and its cause
//   trap_target, mepc_out            - handler address, return address
module csr_machine_file
    import csr_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter bit          VECTORED_EN   = 1'b1,
    parameter logic [31:0] HART_ID       = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din,
    input  logic [11:0] addr,
    input  logic        write_en,
    input  logic        read_en,
    output logic [31:0] dout,
    output logic        illegal,
    input  logic        trap_en,
    input  logic [31:0] trap_pc,
    input  logic        trap_int,
    input  logic [4:0]  trap_cause,
    input  logic [31:0] trap_val,
    input  logic        mret_en,
    input  logic        instret_inc,
    input  logic        irq_mtip,
    input  logic        irq_meip,
    input  logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] irq_local,
    output logic        irq_req,
    output logic [4:0]  irq_cause,
    output logic [31:0] trap_target,
    output logic [31:0] mepc_out
);

    localparam logic [31:0] IRQ_MASK = irqMask(NUM_LOCAL_IRQ);

    logic        mstatusMie_q, mstatusMie_d;
    logic        mstatusMpie_q, mstatusMpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mip_q, mip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mcountinhibit_q, mcountinhibit_d;

    logic [63:0] mcycle, minstret;
    logic [31:0] csrRdata;
    logic        implemented;
    logic        writeOk;
    logic [31:0] irqSrc;
    logic [31:0] pending;
    logic [4:0]  irqCause;

    // Read mux; anything not listed here is unimplemented and reads as zero.
    always_comb begin
        csrRdata    = '0;
        implemented = 1'b1;
        case (addr)
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: csrRdata = '0;
            ADDR_MHARTID:       csrRdata = HART_ID;
            ADDR_MSTATUS: begin
                csrRdata[MSTATUS_MIE]  = mstatusMie_q;
                csrRdata[MSTATUS_MPIE] = mstatusMpie_q;
            end
            ADDR_MISA:          csrRdata = MISA_VALUE;
            ADDR_MIE:           csrRdata = mie_q;
            ADDR_MTVEC:         csrRdata = mtvec_q;
            ADDR_MCOUNTINHIBIT: csrRdata = mcountinhibit_q;
            ADDR_MSCRATCH:      csrRdata = mscratch_q;
            ADDR_MEPC:          csrRdata = mepc_q;
            ADDR_MCAUSE:        csrRdata = mcause_q;
            ADDR_MTVAL:         csrRdata = mtval_q;
            ADDR_MIP:           csrRdata = mip_q;
            ADDR_MCYCLE,   ADDR_CYCLE:    csrRdata = mcycle[31:0];
            ADDR_MCYCLEH,  ADDR_CYCLEH:   csrRdata = mcycle[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:  csrRdata = minstret[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: csrRdata = minstret[63:32];
            default:            implemented = 1'b0;
        endcase
    end

    assign dout = read_en ? csrRdata : 32'd0;

    // Identification CSRs and the whole 0xCxx page are read-only, so writes
    // there are flagged and discarded just like accesses to unknown addresses.
    assign illegal = ((read_en || write_en) && !implemented) ||
                     (write_en && ((addr[11:8] == 4'hC) ||
                                   ((addr >= ADDR_MVENDORID) && (addr <= ADDR_MHARTID))));
    assign writeOk = write_en && !illegal;

    // Gather the hardware interrupt sources into their mip bit positions.
    always_comb begin
        irqSrc          = '0;
        irqSrc[MIP_MTI] = irq_mtip;
        irqSrc[MIP_MEI] = irq_meip;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            irqSrc[MIP_LOCAL_BASE + i] = irq_local[i];
        end
    end

    // Next-state for the trap-related CSRs: trap entry beats mret, and both
    // beat a software write to mstatus/mepc/mcause/mtval on the same edge.
    always_comb begin
        mstatusMie_d  = mstatusMie_q;
        mstatusMpie_d = mstatusMpie_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        if (trap_en) begin
            mstatusMpie_d = mstatusMie_q;
            mstatusMie_d  = 1'b0;
            mepc_d        = {trap_pc[31:2], 2'b00};
            mcause_d      = {trap_int, 26'b0, trap_cause};
            mtval_d       = trap_val;
        end else if (mret_en) begin
            mstatusMie_d  = mstatusMpie_q;
            mstatusMpie_d = 1'b1;
        end else if (writeOk) begin
            case (addr)
                ADDR_MSTATUS: begin
                    mstatusMie_d  = din[MSTATUS_MIE];
                    mstatusMpie_d = din[MSTATUS_MPIE];
                end
                ADDR_MEPC:   mepc_d   = {din[31:2], 2'b00};
                ADDR_MCAUSE: mcause_d = din;
                ADDR_MTVAL:  mtval_d  = din;
                default: ;
            endcase
        end
    end

    // Next-state for the plain software CSRs. Hardware-driven mip bits are
    // sticky: a source that is high this edge sets its bit even if software
    // is writing a zero to it at the same time.
    always_comb begin
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mscratch_d      = mscratch_q;
        mcountinhibit_d = mcountinhibit_q;
        mip_d           = (mip_q & IRQ_MASK) | irqSrc;
        if (writeOk) begin
            case (addr)
                ADDR_MIE:           mie_d           = din & IRQ_MASK;
                ADDR_MTVEC:         mtvec_d         = {din[31:2], 1'b0, VECTORED_EN & din[0]};
                ADDR_MSCRATCH:      mscratch_d      = din;
                ADDR_MCOUNTINHIBIT: mcountinhibit_d = din & ((32'h1 << INHIBIT_CY) | (32'h1 << INHIBIT_IR));
                ADDR_MIP:           mip_d           = (din & IRQ_MASK) | irqSrc;
                default: ;
            endcase
        end
    end

    // All CSR state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstatusMie_q    <= 1'b0;
            mstatusMpie_q   <= 1'b0;
            mie_q           <= '0;
            mip_q           <= '0;
            mtvec_q         <= MTVEC_RESET;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mcountinhibit_q <= '0;
        end else begin
            mstatusMie_q    <= mstatusMie_d;
            mstatusMpie_q   <= mstatusMpie_d;
            mie_q           <= mie_d;
            mip_q           <= mip_d;
            mtvec_q         <= mtvec_d;
            mscratch_q      <= mscratch_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mtval_q         <= mtval_d;
            mcountinhibit_q <= mcountinhibit_d;
        end
    end

    // Fixed-priority interrupt selection: MEI, then MSI, then MTI, then the
    // local lines with the lowest index winning.
    assign pending = mip_q & mie_q;
    assign irq_req = mstatusMie_q && (pending != 32'd0);

    always_comb begin
        irqCause = '0;
        if (irq_req) begin
            if (pending[MIP_MEI])      irqCause = 5'(MIP_MEI);
            else if (pending[MIP_MSI]) irqCause = 5'(MIP_MSI);
            else if (pending[MIP_MTI]) irqCause = 5'(MIP_MTI);
            else begin
                for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
                    if (pending[MIP_LOCAL_BASE + i]) irqCause = 5'(MIP_LOCAL_BASE + i);
                end
            end
        end
    end

    assign irq_cause   = irqCause;
    assign trap_target = {mtvec_q[31:2], 2'b00} +
                         ((mtvec_q[0] && irq_req) ? {25'b0, irqCause, 2'b00} : 32'd0);
    assign mepc_out    = mepc_q;

    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset   (reset),
        .inc     (1'b1),
        .inhibit (mcountinhibit_q[INHIBIT_CY]),
        .wr_lo   (writeOk && (addr == ADDR_MCYCLE)),
        .wr_hi   (writeOk && (addr == ADDR_MCYCLEH)),
        .din     (din),
        .count   (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .reset   (reset),
        .inc     (instret_inc),
        .inhibit (mcountinhibit_q[INHIBIT_IR]),
        .wr_lo   (writeOk && (addr == ADDR_MINSTRET)),
        .wr_hi   (writeOk && (addr == ADDR_MINSTRETH)),
        .din     (din),
        .count   (minstret)
    );

endmodule

// File: doc/csr_machine_file.md
CSR_MACHINE_FILE -- requirements
Module: csr_machine_file

Interface
REQ-001 SHALL have parameter NUM_LOCAL_IRQ, default 4, range 0..16: local interrupt lines mapped to mip/mie bits 16+i.
REQ-002 SHALL have parameter VECTORED_EN, default 1: enables mtvec mode 1 (vectored); 0 forces mtvec[1:0]=0.
REQ-003 SHALL have parameter HART_ID, default 0: value read from mhartid.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports din input 32, addr input 12, write_en input 1, read_en input 1: CSR access.
REQ-007 SHALL have ports dout output 32, illegal output 1: read data, and unimplemented or read-only-write flag.
REQ-008 SHALL have ports trap_en input 1, trap_pc input 32, trap_int input 1, trap_cause input 5, trap_val input 32: trap entry.
REQ-009 SHALL have ports mret_en input 1, instret_inc input 1: trap return and retired-instruction pulse.
REQ-010 SHALL have ports irq_mtip input 1, irq_meip input 1, irq_local input NUM_LOCAL_IRQ: interrupt sources.
REQ-011 SHALL have ports irq_req output 1, irq_cause output 5, trap_target output 32, mepc_out output 32: interrupt request, winning cause, handler address, return address.

Function
REQ-012 SHALL implement mvendorid/marchid/mimpid (0), mhartid (HART_ID), mstatus, misa (0x40000010), mie, mtvec, mcountinhibit 0x320, mscratch, mepc, mcause, mtval, mip, mcycle/mcycleh, minstret/minstreth, read-only aliases cycle/cycleh/instret/instreth (0xC00/0xC80/0xC02/0xC82).
REQ-013 SHALL drive dout combinationally with the addressed CSR when read_en=1, else 0; unimplemented addresses read 0.
REQ-014 SHALL assert illegal combinationally when (read_en|write_en) with an unimplemented addr, or write_en to 0xF11-0xF14 or 0xCxx; the write SHALL have no effect.
REQ-015 SHALL apply writes at the next edge; writable masks: mstatus bits 3,7; mie/mip bits 3,7,11,16+i; mtvec [31:2] and bit 0 when VECTORED_EN; mepc [31:2]; mcountinhibit bits 0,2; mscratch/mcause/mtval all bits.
REQ-016 SHALL update, on a trap_en edge: MPIE<=MIE, MIE<=0, mepc<=trap_pc with [1:0]=0, mcause<={trap_int,26'b0,trap_cause}, mtval<=trap_val.
REQ-017 SHALL update, on an mret_en edge: MIE<=MPIE, MPIE<=1.
REQ-018 SHALL prioritise same-edge events trap_en > mret_en > CSR write for mstatus/mepc/mcause/mtval; a lower-priority write to those CSRs is dropped.
REQ-019 SHALL set mip bits 7, 11, 16+i sticky at an edge where the source input is high; a software write of 0 clears them only if the source is low that edge (set wins).
REQ-020 SHALL drive irq_req = MIE & |(mip & mie), combinationally from registers; source high at edge N gives irq_req high after edge N.
REQ-021 SHALL select irq_cause by fixed priority 11 > 3 > 7 > 16 > 17 > ... > 15+NUM_LOCAL_IRQ; irq_cause=0 when irq_req=0.
REQ-022 SHALL drive trap_target = {mtvec[31:2],2'b00} + (4*irq_cause when mtvec[0]=1 and irq_req=1, else 0); mepc_out = mepc.
REQ-023 SHALL increment 64-bit mcycle every edge unless mcountinhibit[0], and minstret on instret_inc unless mcountinhibit[2], carrying low->high; 0xFFFFFFFF_FFFFFFFF wraps to 0.
REQ-024 SHALL let a CSR write to a counter half load din into that half, leave the other half unchanged, and suppress that counter's increment on the same edge.

Reset
REQ-025 SHALL on reset set mstatus, mie, mip, mscratch, mepc, mcause, mtval, mcountinhibit, both counters to 0, mtvec to 0x00000004; all outputs SHALL read 0 except trap_target=0x00000004.
REQ-026 SHALL clear in-flight effects: a trap_en, mret_en or write coincident with reset assertion has no effect.

Structure
REQ-027 SHALL place CSR address constants, mstatus/mip bit positions, misa value and reset constants in shared package csr_pkg.
REQ-028 SHALL implement each 64-bit counter as sub-module csr_counter64 (inc, inhibit, wr_lo, wr_hi, din, count), instantiated twice.

Verification
REQ-029 SHALL test reset defaults: read all 22 CSRs -> 0 except misa 0x40000010, mtvec 0x4, mhartid HART_ID; read 0x7FF -> illegal=1, dout=0.
REQ-030 SHALL test interrupts: mstatus=0x8, mie=0x10888, pulse irq_local[0] one cycle -> mip=0x10000, irq_req=1, irq_cause=16; then also irq_meip=1 -> irq_cause=11.
REQ-031 SHALL test vectored entry: mtvec=0x1001, mie=0x80, MIE=1, irq_mtip=1 -> trap_target=0x101C; trap_en with cause 7, trap_int=1, pc 0x8AB6 -> mcause 0x80000007, mepc 0x8AB4, mstatus 0x80.
REQ-032 SHALL test mret after that trap -> mstatus 0x88; same-edge trap_en+write mepc=0x1234 -> mepc=trap_pc.
REQ-033 SHALL test counters: write mcycle=0xFFFFFFFE, mcycleh=0 -> after 2 edges mcycleh=1, mcycle=0; mcountinhibit=0x1 -> mcycle frozen; write to 0xC00 -> illegal=1, value unchanged.
